// File: rtl/display_mux.sv
// Two-digit time-multiplexer for the shared seven-segment decoder.
// Holds the last two key codes and alternates the anodes with a blanking gap between digits.
module display_mux #(
    parameter int REFRESH_CYCLES = 24000,
    parameter int BLANK_CYCLES   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] s,
    output logic       an0_n,
    output logic       an1_n,
    output logic [3:0] digit0,
    output logic [3:0] digit1
);

    // state  | meaning
    // SHOW0  | right digit (digit0) lit for REFRESH_CYCLES
    // BLANK0 | both anodes off for BLANK_CYCLES, s moves to digit1
    // SHOW1  | left digit (digit1) lit for REFRESH_CYCLES
    // BLANK1 | both anodes off for BLANK_CYCLES, s moves to digit0; reset state

    localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST   = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            phase_done;
    logic            target;

    always_comb begin
        phase_done = 1'b0;
        if (state == SHOW0 || state == SHOW1)
            phase_done = (counter == REFRESH_LAST);
        else
            phase_done = (counter == BLANK_LAST);
    end

    // Selected digit switches at the start of each blank, so s settles before the anode opens.
    assign target = (state == BLANK0) || (state == SHOW1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BLANK1;
            counter <= '0;
        end else if (phase_done) begin
            counter <= '0;
            unique case (state)
                SHOW0:   state <= BLANK0;
                BLANK0:  state <= SHOW1;
                SHOW1:   state <= BLANK1;
                BLANK1:  state <= SHOW0;
                default: state <= BLANK1;
            endcase
        end else begin
            counter <= counter + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit0 <= 4'h0;
            digit1 <= 4'h0;
        end else if (key_valid) begin
            digit1 <= digit0;
            digit0 <= key_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s <= 4'h0;
        else
            s <= target ? digit1 : digit0;
    end

    // Reset term makes the anodes drop immediately, independent of the state register path.
    assign an0_n = reset | (state != SHOW0);
    assign an1_n = reset | (state != SHOW1);

endmodule

// File: tb/tb_display_mux.sv
// Randomized and directed bench for display_mux, checked against a period-position model
// with a two-entry key history.
module tb_display_mux;
    localparam int R   = 4;
    localparam int B   = 2;
    localparam int PER = 2 * (R + B);

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] s;
    logic       an0_n;
    logic       an1_n;
    logic [3:0] digit0;
    logic [3:0] digit1;

    int checks = 0;
    int errors = 0;

    // model: cycles elapsed since reset release, plus key history and registered s
    int         p;
    logic [3:0] m_d0, m_d1, m_s;

    display_mux #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .s(s), .an0_n(an0_n), .an1_n(an1_n), .digit0(digit0), .digit1(digit1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, p);
        end
    endtask

    function automatic int pos();
        return p % PER;
    endfunction

    task automatic model_reset();
        p = 0; m_d0 = 4'h0; m_d1 = 4'h0; m_s = 4'h0;
    endtask

    task automatic check_all();
        int q;
        logic e0, e1;
        q  = pos();
        e0 = !(q >= B && q < B + R);
        e1 = !(q >= 2 * B + R);
        chk("an0_n", {3'b0, an0_n}, {3'b0, e0});
        chk("an1_n", {3'b0, an1_n}, {3'b0, e1});
        chk("no_overlap", {3'b0, an0_n | an1_n}, 4'h1);
        chk("s", s, m_s);
        chk("digit0", digit0, m_d0);
        chk("digit1", digit1, m_d1);
    endtask

    task automatic step(input logic kv, input logic [3:0] kc);
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        m_s = (pos() >= B + R) ? m_d1 : m_d0;
        if (kv) begin
            m_d1 = m_d0;
            m_d0 = kc;
        end
        p++;
        #1;
        key_valid = 1'b0;
        key_code  = $urandom_range(0, 15);
        check_all();
    endtask

    task automatic idle_until(input int q);
        for (int i = 0; i < PER && pos() != q; i++) step(1'b0, 4'h0);
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        model_reset();
        #1;
        chk("rst_an0_n", {3'b0, an0_n}, 4'h1);
        chk("rst_an1_n", {3'b0, an1_n}, 4'h1);
        chk("rst_s", s, 4'h0);
        chk("rst_digit0", digit0, 4'h0);
        chk("rst_digit1", digit1, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();

        // refresh timing, five full periods with no keys
        for (int i = 0; i < 5 * PER; i++) step(1'b0, $urandom_range(0, 15));

        // two separate strobes
        step(1'b1, 4'hA);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0);
        step(1'b1, 4'h3);
        for (int i = 0; i < PER; i++) step(1'b0, 4'h0);
        chk("entry_digit1", digit1, 4'hA);
        chk("entry_digit0", digit0, 4'h3);

        // held strobe: three shifts
        step(1'b1, 4'h1);
        step(1'b1, 4'h2);
        step(1'b1, 4'h3);
        chk("held_digit0", digit0, 4'h3);
        chk("held_digit1", digit1, 4'h2);

        // key on the last SHOW0 cycle
        idle_until(B + R - 1);
        step(1'b1, 4'h7);
        chk("boundary_digit0", digit0, 4'h7);
        for (int i = 0; i < PER; i++) step(1'b0, 4'h0);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 99) < 30), 4'($urandom_range(0, 15)));

        // async reset in the middle of SHOW1 with digits 5/9
        step(1'b1, 4'h5);
        step(1'b1, 4'h9);
        idle_until(2 * B + R + 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_an1_n", {3'b0, an1_n}, 4'h1);
        chk("midrst_an0_n", {3'b0, an0_n}, 4'h1);
        chk("midrst_digit0", digit0, 4'h0);
        chk("midrst_digit1", digit1, 4'h0);
        chk("midrst_s", s, 4'h0);
        #2 reset = 1'b0;
        model_reset();
        check_all();
        for (int i = 0; i < 2 * PER; i++) step(1'b0, 4'h0);

        // final random burst after restart
        for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
